pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for a 5-stage in-order core.
// Decodes the ID opcode, carries control bits through EX/MEM/WB and resolves hazards.
module pipe_ctrl #(
    parameter int RA_W       = 5,
    parameter int FORWARD_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      id_op,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_zero,
    output logic            id_zero_ext,
    output logic            id_jump,
    output logic            ex_alu_src_b,
    output logic            ex_branch,
    output logic            ex_inv_branch,
    output logic [2:0]      ex_alu_op,
    output logic            mem_mem_write,
    output logic            wb_write_reg,
    output logic            wb_mem_to_reg,
    output logic [RA_W-1:0] wb_dst,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            pc_src_branch
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef struct packed {
        logic            alu_src_b;
        logic            branch;
        logic            inv_branch;
        logic [2:0]      alu_op;
        logic            mem_write;
        logic            write_reg;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
    } idex_t;

    typedef struct packed {
        logic            mem_write;
        logic            write_reg;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic            write_reg;
        logic            mem_to_reg;
        logic [RA_W-1:0] dst;
    } memwb_t;

    logic op_r, op_lw, op_sw, op_beq, op_bne;
    logic op_j, op_addi, op_andi, op_ori;
    logic use_rs, use_rt;
    logic haz, taken, bubble;

    idex_t  dec;
    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    // A stage write (dst != 0) that matches a source the ID instruction reads.
    // Unused sources are already zeroed in dec, so they can never match.
    function automatic logic hit(
        input logic            wr,
        input logic [RA_W-1:0] d,
        input logic [RA_W-1:0] a,
        input logic [RA_W-1:0] b
    );
        return wr && (d != '0) && ((d == a) || (d == b));
    endfunction

    // EX/MEM result wins over MEM/WB because it is the younger write.
    function automatic logic [1:0] fsel(
        input logic [RA_W-1:0] s,
        input logic            ew,
        input logic [RA_W-1:0] ed,
        input logic            ww,
        input logic [RA_W-1:0] wd
    );
        if (ew && (ed != '0) && (ed == s)) begin
            return 2'b01;
        end else if (ww && (wd != '0) && (wd == s)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // One-hot opcode decode; unknown opcodes leave every flag low.
    always_comb begin
        op_r    = 1'b0;
        op_lw   = 1'b0;
        op_sw   = 1'b0;
        op_beq  = 1'b0;
        op_bne  = 1'b0;
        op_j    = 1'b0;
        op_addi = 1'b0;
        op_andi = 1'b0;
        op_ori  = 1'b0;
        case (id_op)
            OP_R:    op_r    = 1'b1;
            OP_LW:   op_lw   = 1'b1;
            OP_SW:   op_sw   = 1'b1;
            OP_BEQ:  op_beq  = 1'b1;
            OP_BNE:  op_bne  = 1'b1;
            OP_J:    op_j    = 1'b1;
            OP_ADDI: op_addi = 1'b1;
            OP_ANDI: op_andi = 1'b1;
            OP_ORI:  op_ori  = 1'b1;
            default: ;
        endcase
    end

    assign use_rs = op_r | op_lw | op_sw | op_beq | op_bne
                  | op_addi | op_andi | op_ori;
    assign use_rt = op_r | op_sw | op_beq | op_bne;

    assign id_zero_ext = op_andi | op_ori;

    // Control word the ID instruction would carry into EX.
    always_comb begin
        dec            = '0;
        dec.alu_src_b  = op_lw | op_sw | op_addi | op_andi | op_ori;
        dec.branch     = op_beq | op_bne;
        dec.inv_branch = op_bne;
        dec.alu_op     = {op_andi | op_ori, op_r, op_beq | op_bne | op_ori};
        dec.mem_write  = op_sw;
        dec.write_reg  = op_r | op_lw | op_addi | op_andi | op_ori;
        dec.mem_to_reg = op_lw;
        dec.dst        = op_r ? id_rd : id_rt;
        dec.rs         = use_rs ? id_rs : '0;
        dec.rt         = use_rt ? id_rt : '0;
    end

    assign taken         = idex_q.branch & (ex_zero ^ idex_q.inv_branch);
    assign pc_src_branch = taken;

    if (FORWARD_EN != 0) begin : g_fwd
        assign haz   = hit(idex_q.mem_to_reg, idex_q.dst, dec.rs, dec.rt);
        assign fwd_a = fsel(idex_q.rs, exmem_q.write_reg, exmem_q.dst,
                            memwb_q.write_reg, memwb_q.dst);
        assign fwd_b = fsel(idex_q.rt, exmem_q.write_reg, exmem_q.dst,
                            memwb_q.write_reg, memwb_q.dst);
    end else begin : g_nofwd
        assign haz   = hit(idex_q.write_reg, idex_q.dst, dec.rs, dec.rt)
                     | hit(exmem_q.write_reg, exmem_q.dst, dec.rs, dec.rt)
                     | hit(memwb_q.write_reg, memwb_q.dst, dec.rs, dec.rt);
        assign fwd_a = 2'b00;
        assign fwd_b = 2'b00;
    end

    // Front-end steering: a taken branch beats a stall, a stall beats a jump.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        id_jump    = 1'b0;
        bubble     = 1'b0;
        if (taken) begin
            ifid_flush = 1'b1;
            bubble     = 1'b1;
        end else if (haz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
        end else if (op_j) begin
            id_jump    = 1'b1;
            ifid_flush = 1'b1;
        end
    end

    // Next-state for the three stage registers; the back two always advance.
    always_comb begin
        idex_d             = bubble ? '0 : dec;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.write_reg  = idex_q.write_reg;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.dst        = idex_q.dst;
        memwb_d.write_reg  = exmem_q.write_reg;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.dst        = exmem_q.dst;
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_src_b  = idex_q.alu_src_b;
    assign ex_branch     = idex_q.branch;
    assign ex_inv_branch = idex_q.inv_branch;
    assign ex_alu_op     = idex_q.alu_op;
    assign mem_mem_write = exmem_q.mem_write;
    assign wb_write_reg  = memwb_q.write_reg;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_dst        = memwb_q.dst;

endmodule
